serial_sub_4bit: RTL and testbench



---
 rtl/serial_sub_4bit_if.sv | 33 +++
 rtl/serial_sub_4bit.sv | 104 ++++++++++
 tb/tb_serial_sub_4bit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_4bit_if.sv
// Start/done handshake bundle for serial_sub_4bit.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_4bit_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
`ifdef SERIAL_SUB_OVF_EN
        input  ovf,
`endif
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow_out
    );

    modport slave (
`ifdef SERIAL_SUB_OVF_EN
        output ovf,
`endif
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_sub_4bit.sv
// Bit-serial subtractor: a - b - borrow_in, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_4bit #(
    parameter int WIDTH = 4
) (
    input logic              clk,
    input logic              rst,
    serial_sub_4bit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    cnt;
    logic             br, br_nx, d, last;
    logic             borrow_r;
    logic             busy_c, done_c;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_r;
`endif

    assign d     = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign last  = (cnt == LAST);
    // Result register keeps only the upper WIDTH-1 bits; the newest bit joins at completion.
    assign res_nx = {d, res_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) state_nx = SHIFT;
            SHIFT: begin
                busy_c = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    a_sr   <= bus.a;
                    b_sr   <= bus.b;
                    br     <= bus.borrow_in;
                    res_sr <= '0;
                    cnt    <= '0;
                end
                SHIFT: begin
                    res_sr <= res_nx[WIDTH-1:1];
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_nx;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff_r   <= res_nx;
                        borrow_r <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_r    <= br ^ br_nx;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_r;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf        = ovf_r;
`endif
endmodule

// File: tb/tb_serial_sub_4bit.sv
// Directed self-checking bench for serial_sub_4bit (WIDTH=4).
module tb_serial_sub_4bit;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_sub_4bit_if #(.WIDTH(W)) bus ();
    serial_sub_4bit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Issues one operation from IDLE and returns observations; leaves the DUT back in IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output int lat, output int busy_n, output int overlap);
        bus.a = a; bus.b = b; bus.borrow_in = bin; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        lat = 0; busy_n = 0; overlap = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) lat = i;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        n_checks++; if (bus.diff !== 4'h0) begin n_fail++; $display("FAIL reset_diff: got %h expected 0", bus.diff); end
        n_checks++; if (bus.borrow_out !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b expected 0", bus.borrow_out); end
`ifdef SERIAL_SUB_OVF_EN
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
`endif
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: busy got %b expected 0", bus.busy); end
    endtask

    task automatic test_subtract();
        logic [W-1:0] va [6];
        logic [W-1:0] vb [6];
        logic         vi [6];
        logic [W-1:0] ed [6];
        logic         eb [6];
        int lat, busy_n, overlap;
        va[0]=4'h9; vb[0]=4'h3; vi[0]=1'b0; ed[0]=4'h6; eb[0]=1'b0;
        va[1]=4'h3; vb[1]=4'h9; vi[1]=1'b0; ed[1]=4'hA; eb[1]=1'b1;
        va[2]=4'h0; vb[2]=4'h0; vi[2]=1'b1; ed[2]=4'hF; eb[2]=1'b1;
        va[3]=4'h7; vb[3]=4'h7; vi[3]=1'b1; ed[3]=4'hF; eb[3]=1'b1;
        va[4]=4'hF; vb[4]=4'h0; vi[4]=1'b1; ed[4]=4'hE; eb[4]=1'b0;
        va[5]=4'hA; vb[5]=4'h5; vi[5]=1'b0; ed[5]=4'h5; eb[5]=1'b0;
        for (int k = 0; k < 6; k++) begin
            do_op(va[k], vb[k], vi[k], lat, busy_n, overlap);
            n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sub%0d_latency: got %0d expected 5", k, lat); end
            n_checks++; if (busy_n !== 4) begin n_fail++; $display("FAIL sub%0d_busy_cycles: got %0d expected 4", k, busy_n); end
            n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL sub%0d_busy_done_overlap: got %0d expected 0", k, overlap); end
            n_checks++; if (bus.diff !== ed[k]) begin n_fail++; $display("FAIL sub%0d_diff: got %h expected %h", k, bus.diff, ed[k]); end
            n_checks++; if (bus.borrow_out !== eb[k]) begin n_fail++; $display("FAIL sub%0d_borrow: got %b expected %b", k, bus.borrow_out, eb[k]); end
        end
    endtask

    task automatic test_start_ignored();
        int dones = 0, done_at = 0;
        logic [W-1:0] d_at = 'x, d_late = 'x;
        logic bo_at = 1'bx;
        bus.a = 4'h5; bus.b = 4'h2; bus.borrow_in = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 2) begin bus.start = 1'b1; bus.a = 4'h1; bus.b = 4'h7; end
            if (i == 3) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (dones == 1) begin done_at = i; d_at = bus.diff; bo_at = bus.borrow_out; end
            end
            if (done_at != 0 && i == done_at + 3) d_late = bus.diff;
        end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
        n_checks++; if (d_at !== 4'h3) begin n_fail++; $display("FAIL ignore_diff: got %h expected 3", d_at); end
        n_checks++; if (bo_at !== 1'b0) begin n_fail++; $display("FAIL ignore_borrow: got %b expected 0", bo_at); end
        n_checks++; if (d_late !== 4'h3) begin n_fail++; $display("FAIL ignore_diff_hold: got %h expected 3", d_late); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int lat, busy_n, overlap;
        bus.a = 4'hF; bus.b = 4'h1; bus.borrow_in = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.diff !== 4'h0) begin n_fail++; $display("FAIL midrst_diff: got %h expected 0", bus.diff); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", dones); end
        @(posedge clk); #1;
        do_op(4'hF, 4'h1, 1'b0, lat, busy_n, overlap);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL postrst_latency: got %0d expected 5", lat); end
        n_checks++; if (bus.diff !== 4'hE) begin n_fail++; $display("FAIL postrst_diff: got %h expected e", bus.diff); end
        n_checks++; if (bus.borrow_out !== 1'b0) begin n_fail++; $display("FAIL postrst_borrow: got %b expected 0", bus.borrow_out); end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        int lat, busy_n, overlap;
        do_op(4'h8, 4'h1, 1'b0, lat, busy_n, overlap);
        n_checks++; if (bus.diff !== 4'h7) begin n_fail++; $display("FAIL ovf1_diff: got %h expected 7", bus.diff); end
        n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf1_ovf: got %b expected 1", bus.ovf); end
        n_checks++; if (bus.borrow_out !== 1'b0) begin n_fail++; $display("FAIL ovf1_borrow: got %b expected 0", bus.borrow_out); end
        do_op(4'h2, 4'h1, 1'b0, lat, busy_n, overlap);
        n_checks++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf2_ovf: got %b expected 0", bus.ovf); end
        do_op(4'h7, 4'hF, 1'b0, lat, busy_n, overlap);
        n_checks++; if (bus.diff !== 4'h8) begin n_fail++; $display("FAIL ovf3_diff: got %h expected 8", bus.diff); end
        n_checks++; if (bus.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf3_ovf: got %b expected 1", bus.ovf); end
        n_checks++; if (bus.borrow_out !== 1'b1) begin n_fail++; $display("FAIL ovf3_borrow: got %b expected 1", bus.borrow_out); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vi [3];
        logic [W-1:0] ed [3];
        logic         eb [3];
        logic [W-1:0] gd [3];
        logic         gb [3];
        int t [3];
        int acc = 0, done_n = 0, overlap = 0;
        logic busy_prev = 1'b0;
        va[0]=4'h9; vb[0]=4'h3; vi[0]=1'b0; ed[0]=4'h6; eb[0]=1'b0;
        va[1]=4'h3; vb[1]=4'h9; vi[1]=1'b0; ed[1]=4'hA; eb[1]=1'b1;
        va[2]=4'hC; vb[2]=4'h4; vi[2]=1'b1; ed[2]=4'h7; eb[2]=1'b0;
        for (int k = 0; k < 3; k++) begin t[k] = 0; gd[k] = 'x; gb[k] = 1'bx; end
        bus.a = va[0]; bus.b = vb[0]; bus.borrow_in = vi[0]; bus.start = 1'b1;
        for (int i = 1; i <= 40 && done_n < 3; i++) begin
            @(negedge clk);
            if (bus.busy && !busy_prev) begin
                acc++;
                if (acc < 3) begin bus.a = va[acc]; bus.b = vb[acc]; bus.borrow_in = vi[acc]; end
                else bus.start = 1'b0;
            end
            busy_prev = bus.busy;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                t[done_n] = i; gd[done_n] = bus.diff; gb[done_n] = bus.borrow_out;
                done_n++;
            end
        end
        bus.start = 1'b0;
        n_checks++; if (done_n !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", done_n); end
        n_checks++; if (t[1] - t[0] !== 6) begin n_fail++; $display("FAIL b2b_spacing01: got %0d expected 6", t[1] - t[0]); end
        n_checks++; if (t[2] - t[1] !== 6) begin n_fail++; $display("FAIL b2b_spacing12: got %0d expected 6", t[2] - t[1]); end
        n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL b2b_busy_done_overlap: got %0d expected 0", overlap); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (gd[k] !== ed[k]) begin n_fail++; $display("FAIL b2b%0d_diff: got %h expected %h", k, gd[k], ed[k]); end
            n_checks++; if (gb[k] !== eb[k]) begin n_fail++; $display("FAIL b2b%0d_borrow: got %b expected %b", k, gb[k], eb[k]); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_subtract();
        test_start_ignored();
        test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end
endmodule
